// File: rtl/result_accumulator.sv
// result_accumulator: per-channel frame reduction of signed partial sums with
// saturating accumulation, rounding shift, output saturation and sideband capture.
module result_accumulator #(
    parameter int CHANNELS            = 1,
    parameter int DATA_WIDTH_IN       = 16,
    parameter int FRACTIONAL_BITS_IN  = 12,
    parameter int DATA_WIDTH_OUT      = 16,
    parameter int FRACTIONAL_BITS_OUT = 12,
    parameter int ACC_WIDTH           = 24,
    parameter int ID_ENABLE           = 0,
    parameter int ID_WIDTH            = 8,
    parameter int DEST_ENABLE         = 0,
    parameter int DEST_WIDTH          = 8,
    parameter int USER_ENABLE         = 0,
    parameter int USER_WIDTH          = 1,
    parameter int KEEP_WIDTH          = (DATA_WIDTH_OUT + 7) / 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS*DATA_WIDTH_IN-1:0]   s_axis_tdata,
    input  logic [CHANNELS-1:0]                 s_axis_tvalid,
    output logic [CHANNELS-1:0]                 s_axis_tready,
    input  logic [CHANNELS-1:0]                 s_axis_tlast,
    input  logic [CHANNELS*ID_WIDTH-1:0]        s_axis_tid,
    input  logic [CHANNELS*DEST_WIDTH-1:0]      s_axis_tdest,
    input  logic [CHANNELS*USER_WIDTH-1:0]      s_axis_tuser,
    output logic [CHANNELS*DATA_WIDTH_OUT-1:0]  m_axis_tdata,
    output logic [CHANNELS*KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic [CHANNELS-1:0]                 m_axis_tvalid,
    input  logic [CHANNELS-1:0]                 m_axis_tready,
    output logic [CHANNELS-1:0]                 m_axis_tlast,
    output logic [CHANNELS*ID_WIDTH-1:0]        m_axis_tid,
    output logic [CHANNELS*DEST_WIDTH-1:0]      m_axis_tdest,
    output logic [CHANNELS*USER_WIDTH-1:0]      m_axis_tuser,
    output logic [CHANNELS-1:0]                 err_overflow
);
    localparam int S  = FRACTIONAL_BITS_IN - FRACTIONAL_BITS_OUT;
    localparam int RW = ACC_WIDTH + 2 > DATA_WIDTH_OUT + 1 ? ACC_WIDTH + 2 : DATA_WIDTH_OUT + 1;
    localparam logic signed [RW-1:0] HALF = S > 0 ? RW'(1) << (S > 0 ? S - 1 : 0) : RW'(0);
    localparam logic signed [RW-1:0] OMAX = {{(RW-DATA_WIDTH_OUT+1){1'b0}}, {(DATA_WIDTH_OUT-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = ~OMAX;
    localparam logic [ID_WIDTH-1:0]   ID_MASK   = {ID_WIDTH{ID_ENABLE != 0}};
    localparam logic [DEST_WIDTH-1:0] DEST_MASK = {DEST_WIDTH{DEST_ENABLE != 0}};
    localparam logic [USER_WIDTH-1:0] USER_MASK = {USER_WIDTH{USER_ENABLE != 0}};

    if (FRACTIONAL_BITS_OUT > FRACTIONAL_BITS_IN) begin : g_bad_frac
        $error("FRACTIONAL_BITS_OUT must not exceed FRACTIONAL_BITS_IN");
    end
    if (ACC_WIDTH < DATA_WIDTH_IN) begin : g_bad_acc
        $error("ACC_WIDTH must be at least DATA_WIDTH_IN");
    end

    assign m_axis_tkeep = '1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DATA_WIDTH_IN-1:0]  din;
        logic [ACC_WIDTH-1:0]      acc_q, acc_d, base, final_v;
        logic [ACC_WIDTH:0]        sum;
        logic signed [RW-1:0]      fx, rnd;
        logic [DATA_WIDTH_OUT-1:0] dat_q, dat_d, res;
        logic [ID_WIDTH-1:0]       id_q, id_d;
        logic [DEST_WIDTH-1:0]     dest_q, dest_d;
        logic [USER_WIDTH-1:0]     user_q, user_d;
        logic first_q, first_d, stk_q, stk_d, vld_q, vld_d, err_q, err_d;
        logic accept, load, ovf, osat, stk_eff;

        assign din              = s_axis_tdata[g*DATA_WIDTH_IN +: DATA_WIDTH_IN];
        assign s_axis_tready[g] = !vld_q || m_axis_tready[g];
        assign accept           = s_axis_tvalid[g] && s_axis_tready[g];
        assign load             = accept && s_axis_tlast[g];

        // The first beat of a frame adds onto zero, so it loads tdata directly.
        always_comb begin
            base    = first_q ? '0 : acc_q;
            sum     = {base[ACC_WIDTH-1], base} + {{(ACC_WIDTH-DATA_WIDTH_IN+1){din[DATA_WIDTH_IN-1]}}, din};
            ovf     = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
            final_v = ovf ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){!sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
            fx      = {{(RW-ACC_WIDTH){final_v[ACC_WIDTH-1]}}, final_v};
            rnd     = (fx + HALF) >>> S;
            osat    = rnd > OMAX || rnd < OMIN;
            res     = osat ? {rnd[RW-1], {(DATA_WIDTH_OUT-1){!rnd[RW-1]}}} : rnd[DATA_WIDTH_OUT-1:0];
            stk_eff = (!first_q && stk_q) || ovf;
            acc_d   = accept && !s_axis_tlast[g] ? final_v : acc_q;
            first_d = accept ? s_axis_tlast[g] : first_q;
            stk_d   = accept ? !s_axis_tlast[g] && stk_eff : stk_q;
            vld_d   = load || (vld_q && !m_axis_tready[g]);
            dat_d   = load ? res : dat_q;
            err_d   = load && (stk_eff || osat);
            id_d    = load ? s_axis_tid[g*ID_WIDTH +: ID_WIDTH] & ID_MASK : id_q;
            dest_d  = load ? s_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH] & DEST_MASK : dest_q;
            user_d  = load ? s_axis_tuser[g*USER_WIDTH +: USER_WIDTH] & USER_MASK : user_q;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                acc_q   <= '0;
                first_q <= 1'b1;
                stk_q   <= 1'b0;
                vld_q   <= 1'b0;
                dat_q   <= '0;
                err_q   <= 1'b0;
                id_q    <= '0;
                dest_q  <= '0;
                user_q  <= '0;
            end else begin
                acc_q   <= acc_d;
                first_q <= first_d;
                stk_q   <= stk_d;
                vld_q   <= vld_d;
                dat_q   <= dat_d;
                err_q   <= err_d;
                id_q    <= id_d;
                dest_q  <= dest_d;
                user_q  <= user_d;
            end
        end

        assign m_axis_tdata[g*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = dat_q;
        assign m_axis_tvalid[g]                                 = vld_q;
        assign m_axis_tlast[g]                                  = vld_q;
        assign m_axis_tid[g*ID_WIDTH +: ID_WIDTH]               = id_q;
        assign m_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH]         = dest_q;
        assign m_axis_tuser[g*USER_WIDTH +: USER_WIDTH]         = user_q;
        assign err_overflow[g]                                  = err_q;
    end
endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator: directed frames on a two-channel default instance (lanes 0,1)
// and a one-channel FRACTIONAL_BITS_OUT=8 instance (lane 2), checked against a behavioural model.
module tb_result_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ld [3];
    logic        lv [3], ll [3], lmr [3];
    logic [7:0]  lid [3];
    logic [15:0] o_dat [3];
    logic        o_rdy [3], o_vld [3], o_last [3], o_err [3];
    logic [7:0]  o_id [3];

    logic [31:0] a_mdata;
    logic [1:0]  a_tready, a_mvalid, a_mlast, a_err, a_muser;
    logic [15:0] a_mid, a_mdest;
    logic [3:0]  a_keep;
    logic [15:0] b_mdata;
    logic        b_tready, b_mvalid, b_mlast, b_err, b_muser;
    logic [7:0]  b_mid, b_mdest;
    logic [1:0]  b_keep;

    result_accumulator #(.CHANNELS(2), .ID_ENABLE(1)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata({ld[1], ld[0]}), .s_axis_tvalid({lv[1], lv[0]}), .s_axis_tready(a_tready),
        .s_axis_tlast({ll[1], ll[0]}), .s_axis_tid({lid[1], lid[0]}), .s_axis_tdest(16'h3C3C),
        .s_axis_tuser(2'b11), .m_axis_tdata(a_mdata), .m_axis_tkeep(a_keep), .m_axis_tvalid(a_mvalid),
        .m_axis_tready({lmr[1], lmr[0]}), .m_axis_tlast(a_mlast), .m_axis_tid(a_mid),
        .m_axis_tdest(a_mdest), .m_axis_tuser(a_muser), .err_overflow(a_err)
    );

    result_accumulator #(.CHANNELS(1), .FRACTIONAL_BITS_OUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(ld[2]), .s_axis_tvalid(lv[2]), .s_axis_tready(b_tready),
        .s_axis_tlast(ll[2]), .s_axis_tid(lid[2]), .s_axis_tdest(8'hA5), .s_axis_tuser(1'b1),
        .m_axis_tdata(b_mdata), .m_axis_tkeep(b_keep), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(lmr[2]), .m_axis_tlast(b_mlast), .m_axis_tid(b_mid),
        .m_axis_tdest(b_mdest), .m_axis_tuser(b_muser), .err_overflow(b_err)
    );

    assign o_dat[0] = a_mdata[15:0];
    assign o_dat[1] = a_mdata[31:16];
    assign o_dat[2] = b_mdata;
    assign o_rdy[0] = a_tready[0];
    assign o_rdy[1] = a_tready[1];
    assign o_rdy[2] = b_tready;
    assign o_vld[0] = a_mvalid[0];
    assign o_vld[1] = a_mvalid[1];
    assign o_vld[2] = b_mvalid;
    assign o_last[0] = a_mlast[0];
    assign o_last[1] = a_mlast[1];
    assign o_last[2] = b_mlast;
    assign o_err[0] = a_err[0];
    assign o_err[1] = a_err[1];
    assign o_err[2] = b_err;
    assign o_id[0] = a_mid[7:0];
    assign o_id[1] = a_mid[15:8];
    assign o_id[2] = b_mid;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int lane, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got %0h, expected %0h", nm, lane, act, exp);
        end
    endtask

    // Behavioural model: integer accumulation with explicit clamping.
    int   lane_s [3]     = '{0, 0, 4};
    logic lane_id_en [3] = '{1'b1, 1'b1, 1'b0};
    longint      e_acc [3];
    logic        e_first [3], e_stk [3], e_vld [3], e_err [3];
    logic [15:0] e_dat [3];
    logic [7:0]  e_id [3];

    function automatic longint clamp(input longint v, input int w, output logic sat);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        sat = v > hi || v < lo;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    function automatic longint shift_round(input longint v, input int s);
        if (s == 0) return v;
        return (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            longint sm, r;
            logic ov, os, stk, rdy;
            if (!rst) begin
                e_acc[i] <= 0; e_first[i] <= 1'b1; e_stk[i] <= 1'b0;
                e_vld[i] <= 1'b0; e_err[i] <= 1'b0; e_dat[i] <= '0; e_id[i] <= '0;
            end else begin
                rdy = !e_vld[i] || lmr[i];
                e_err[i] <= 1'b0;
                if (e_vld[i] && lmr[i]) e_vld[i] <= 1'b0;
                if (lv[i] && rdy) begin
                    sm = clamp((e_first[i] ? 64'sd0 : e_acc[i]) + longint'($signed(ld[i])), 24, ov);
                    stk = (!e_first[i] && e_stk[i]) || ov;
                    if (ll[i]) begin
                        r = clamp(shift_round(sm, lane_s[i]), 16, os);
                        e_vld[i] <= 1'b1;
                        e_dat[i] <= 16'(r);
                        e_err[i] <= stk || os;
                        e_first[i] <= 1'b1;
                        e_stk[i] <= 1'b0;
                        e_id[i] <= lane_id_en[i] ? lid[i] : 8'h00;
                    end else begin
                        e_acc[i] <= sm;
                        e_first[i] <= 1'b0;
                        e_stk[i] <= stk;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("tready", i, o_rdy[i], !e_vld[i] || lmr[i]);
                chk("tvalid", i, o_vld[i], e_vld[i]);
                chk("err_overflow", i, o_err[i], e_err[i]);
                if (e_vld[i]) begin
                    chk("tdata", i, o_dat[i], e_dat[i]);
                    chk("tlast", i, o_last[i], 1);
                    chk("tid", i, o_id[i], e_id[i]);
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int lane, input logic [15:0] d, input logic last, input logic [7:0] id);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        lv[lane] = 1'b1; ld[lane] = d; ll[lane] = last; lid[lane] = id;
        while (!done) begin
            @(negedge clk);
            done = o_rdy[lane];
            align();
            n++;
            if (!done && n >= 200) begin
                n_chk++;
                n_err++;
                $display("FAIL send_timeout lane%0d: tready low for %0d cycles, required within 200", lane, n);
                done = 1'b1;
            end
        end
        lv[lane] = 1'b0; ll[lane] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0; ll[i] = 1'b0; ld[i] = '0; lid[i] = '0; lmr[i] = 1'b1;
        end
        @(posedge clk);
        #1 chk_en = 1'b1;
        align();
        align();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_reset_tready", 0, o_rdy[0], 1);
        chk("lit_reset_tvalid", 0, o_vld[0], 0);
        chk("lit_reset_tdata", 0, o_dat[0], 0);
        chk("lit_reset_err", 0, o_err[0], 0);
        align();

        send(0, 16'h0100, 1'b0, 8'h11);
        send(0, 16'h0200, 1'b0, 8'h22);
        send(0, 16'h0300, 1'b1, 8'h5A);
        @(negedge clk);
        chk("lit_sum_tvalid", 0, o_vld[0], 1);
        chk("lit_sum_tdata", 0, o_dat[0], 16'h0600);
        chk("lit_sum_tlast", 0, o_last[0], 1);
        chk("lit_sum_tid", 0, o_id[0], 8'h5A);
        chk("lit_tkeep", 0, a_keep, 4'hF);
        chk("lit_tdest_off", 0, a_mdest, 0);
        chk("lit_tuser_off", 0, a_muser, 0);
        @(negedge clk);
        chk("lit_single_output", 0, o_vld[0], 0);
        align();

        send(2, 16'h0018, 1'b1, 8'h77);
        @(negedge clk);
        chk("lit_round_up", 2, o_dat[2], 16'h0002);
        chk("lit_tid_off", 2, o_id[2], 0);
        chk("lit_tdest_off", 2, b_mdest, 0);
        chk("lit_tkeep", 2, b_keep, 2'h3);
        align();
        send(2, 16'h0017, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_round_down", 2, o_dat[2], 16'h0001);
        align();
        send(2, 16'hFFE8, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_round_neg", 2, o_dat[2], 16'hFFFF);
        align();

        send(0, 16'h7000, 1'b0, 8'h00);
        send(0, 16'h7000, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_sat_pos", 0, o_dat[0], 16'h7FFF);
        chk("lit_sat_pos_err", 0, o_err[0], 1);
        align();
        send(0, 16'h9000, 1'b0, 8'h00);
        send(0, 16'h9000, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_sat_neg", 0, o_dat[0], 16'h8000);
        chk("lit_sat_neg_err", 0, o_err[0], 1);
        @(negedge clk);
        chk("lit_err_pulse", 0, o_err[0], 0);
        align();
        for (int k = 0; k < 259; k++) send(0, 16'h7FFF, 1'b0, 8'h00);
        send(0, 16'h7FFF, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_acc_clamp", 0, o_dat[0], 16'h7FFF);
        align();
        send(0, 16'h0001, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_sticky_clear", 0, o_err[0], 0);
        chk("lit_single_beat", 0, o_dat[0], 16'h0001);
        align();

        send(0, 16'h0005, 1'b1, 8'h00);
        send(0, 16'h0006, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_back_to_back", 0, o_dat[0], 16'h0006);
        align();

        lmr[0] = 1'b0;
        send(0, 16'h0010, 1'b0, 8'h00);
        send(0, 16'h0020, 1'b1, 8'h33);
        fork
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("lit_stall_tready", 0, o_rdy[0], 0);
                    chk("lit_stall_tdata", 0, o_dat[0], 16'h0030);
                end
                align();
                lmr[0] = 1'b1;
            end
            begin
                send(0, 16'h0100, 1'b0, 8'h00);
                send(0, 16'h0001, 1'b0, 8'h00);
                send(0, 16'h0002, 1'b1, 8'h44);
            end
        join
        @(negedge clk);
        chk("lit_after_stall", 0, o_dat[0], 16'h0103);
        chk("lit_after_stall_tid", 0, o_id[0], 8'h44);
        align();

        lmr[1] = 1'b0;
        send(1, 16'h0040, 1'b1, 8'h41);
        fork
            begin
                send(1, 16'h0007, 1'b0, 8'h00);
                send(1, 16'h0003, 1'b1, 8'h42);
            end
            begin
                send(0, 16'h0011, 1'b1, 8'h00);
                @(negedge clk);
                chk("lit_ch0_indep1", 0, o_dat[0], 16'h0011);
                align();
                send(0, 16'h0022, 1'b0, 8'h00);
                send(0, 16'h0033, 1'b1, 8'h00);
                @(negedge clk);
                chk("lit_ch0_indep2", 0, o_dat[0], 16'h0055);
                chk("lit_ch1_held", 1, o_dat[1], 16'h0040);
                chk("lit_ch1_stalled", 1, o_rdy[1], 0);
                align();
                lmr[1] = 1'b1;
            end
        join
        @(negedge clk);
        chk("lit_ch1_next", 1, o_dat[1], 16'h000A);
        align();

        lmr[1] = 1'b0;
        send(1, 16'h0009, 1'b1, 8'h00);
        send(0, 16'h0100, 1'b0, 8'h00);
        send(0, 16'h0200, 1'b0, 8'h00);
        rst = 1'b0;
        align();
        @(negedge clk);
        chk("lit_rst_tvalid0", 0, o_vld[0], 0);
        chk("lit_rst_tvalid1", 1, o_vld[1], 0);
        align();
        rst = 1'b1;
        lmr[1] = 1'b1;
        send(0, 16'h0001, 1'b1, 8'h00);
        @(negedge clk);
        chk("lit_post_reset", 0, o_dat[0], 16'h0001);
        chk("lit_post_reset_vld", 0, o_vld[0], 1);
        repeat (3) align();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
